// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves both ALU operands through EX/MEM/WB forwarding,
// detects load-use hazards (stall + bubble) and supports a branch flush.
module id_ex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               DecValid,
  input  logic [REGBITS-1:0] DecRs,
  input  logic [REGBITS-1:0] DecRt,
  input  logic [REGBITS-1:0] DecRd,
  input  logic [WIDTH-1:0]   DecRsData,
  input  logic [WIDTH-1:0]   DecRtData,
  input  logic [WIDTH-1:0]   DecImm,
  input  logic               DecAluSrc,
  input  logic [2:0]         DecAluCtrl,
  input  logic               DecRegWrite,
  input  logic               DecMemRead,
  input  logic               DecMemWrite,
  input  logic [WIDTH-1:0]   ExAluResult,
  input  logic               MemRegWrite,
  input  logic [REGBITS-1:0] MemRd,
  input  logic [WIDTH-1:0]   MemResult,
  input  logic               WbRegWrite,
  input  logic [REGBITS-1:0] WbRd,
  input  logic [WIDTH-1:0]   WbResult,
  input  logic               Flush,
  output logic               ExValid,
  output logic [WIDTH-1:0]   In0,
  output logic [WIDTH-1:0]   In1,
  output logic [WIDTH-1:0]   ExStoreData,
  output logic [2:0]         AluCtrl,
  output logic [REGBITS-1:0] ExRd,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               StallDec
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  logic             rs_used;
  logic             rt_used;
  logic             hz;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // Youngest producer wins; a load in EX has no result yet and is left to the stall.
  function automatic logic [WIDTH-1:0] forward(input logic [REGBITS-1:0] s,
                                               input logic [WIDTH-1:0]   rf);
    logic [WIDTH-1:0] r;
    r = rf;
    if (s != '0) begin
      if (ExValid && ExRegWrite && !ExMemRead && ExRd == s) r = ExAluResult;
      else if (MemRegWrite && MemRd == s)                   r = MemResult;
      else if (WbRegWrite && WbRd == s)                     r = WbResult;
    end
    return r;
  endfunction

  always_comb begin
    rs_used = DecValid;
    rt_used = DecValid & (~DecAluSrc | DecMemWrite);
    fwd_rs  = forward(DecRs, DecRsData);
    fwd_rt  = forward(DecRt, DecRtData);
    hz      = ExValid & ExMemRead & (ExRd != '0) &
              ((rs_used & (ExRd == DecRs)) | (rt_used & (ExRd == DecRt)));
  end

  assign StallDec = Rst_n & hz & ~Flush;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ExValid     <= 1'b0;
      In0         <= '0;
      In1         <= '0;
      ExStoreData <= '0;
      AluCtrl     <= '0;
      ExRd        <= '0;
      ExRegWrite  <= 1'b0;
      ExMemRead   <= 1'b0;
      ExMemWrite  <= 1'b0;
    end else if (Flush || hz || !DecValid) begin
      ExValid     <= 1'b0;
      In0         <= '0;
      In1         <= '0;
      ExStoreData <= '0;
      AluCtrl     <= ALU_ADD;
      ExRd        <= '0;
      ExRegWrite  <= 1'b0;
      ExMemRead   <= 1'b0;
      ExMemWrite  <= 1'b0;
    end else begin
      ExValid     <= 1'b1;
      In0         <= fwd_rs;
      In1         <= DecAluSrc ? DecImm : fwd_rt;
      ExStoreData <= fwd_rt;
      AluCtrl     <= DecAluCtrl;
      ExRd        <= DecRd;
      ExRegWrite  <= DecRegWrite;
      ExMemRead   <= DecMemRead;
      ExMemWrite  <= DecMemWrite;
    end
  end

endmodule
